// File: rtl/con_pkg.sv
// rtl/con_pkg.sv - shared types and width helpers for the consumer-side word packer
//
// Contents:
//   con_pack_state_e : packer FSM states (IDLE, WAIT, EMIT)
//   con_cnt_width()  : bits needed to hold a counter that reaches max_val inclusive
//   con_idx_width()  : lane-index width for a word of n_lanes lanes (index reaches n_lanes)
//   con_idle_width() : idle-counter width for a timeout of t cycles
package con_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2
    } con_pack_state_e;

    function automatic int con_cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int con_idx_width(input int n_lanes);
        return con_cnt_width(n_lanes);
    endfunction

    function automatic int con_idle_width(input int t);
        return con_cnt_width(t);
    endfunction

endpackage

// File: rtl/con_word_packer.sv
// rtl/con_word_packer.sv - pops FIFO bytes one at a time and packs them into wide words
//
// Optional feature macro: PACK_PARITY_EN (adds OUT_PARITY, even parity over OUT_DATA).
//
// Ports:
//   CON_CLK     in   consumer clock
//   RST         in   synchronous active-high reset
//   FIFO_EMPTY  in   FIFO empty flag, sampled only in IDLE
//   FIFO_DATA   in   FIFO read data, valid P_RD_LAT cycles after the FIFO_R_EN cycle
//   FIFO_R_EN   out  single-cycle read request, only ever high in IDLE
//   OUT_DATA    out  packed word, lane 0 (LSBs) is the first byte popped
//   OUT_CNT     out  number of valid lanes in OUT_DATA
//   OUT_PARITY  out  XOR of all OUT_DATA bits (PACK_PARITY_EN only)
//   OUT_VALID   out  word available
//   OUT_READY   in   downstream accepts the word
module con_word_packer
    import con_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_PACK       = 4,
    parameter int P_RD_LAT     = 2,
    parameter int P_TIMEOUT    = 16
) (
    input  logic                             CON_CLK,
    input  logic                             RST,
    input  logic                             FIFO_EMPTY,
    input  logic [P_DATA_WIDTH-1:0]          FIFO_DATA,
    output logic                             FIFO_R_EN,
    output logic [P_PACK*P_DATA_WIDTH-1:0]   OUT_DATA,
    output logic [$clog2(P_PACK+1)-1:0]      OUT_CNT,
`ifdef PACK_PARITY_EN
    output logic                             OUT_PARITY,
`endif
    output logic                             OUT_VALID,
    input  logic                             OUT_READY
);

    localparam int IDX_W  = con_idx_width(P_PACK);
    localparam int LAT_W  = con_cnt_width(P_RD_LAT);
    localparam int IDLE_W = con_idle_width(P_TIMEOUT);
    localparam int WORD_W = P_PACK * P_DATA_WIDTH;

    con_pack_state_e   state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [WORD_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_cnt_q, out_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              fifo_r_en;

    // State register
    always_ff @(posedge CON_CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            lat_q       <= '0;
            idle_q      <= '0;
            lane_q      <= '0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            idle_q      <= idle_d;
            lane_q      <= lane_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        idle_d      = idle_q;
        lane_d      = lane_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (!FIFO_EMPTY) begin
                    lat_d   = LAT_W'(P_RD_LAT);
                    idle_d  = '0;
                    state_d = WAIT;
                end else if (idx_q != '0) begin
                    idle_d = idle_q + 1'b1;
                    // Partial word: unfilled lanes are still zero from the last clear.
                    if (idle_d == IDLE_W'(P_TIMEOUT)) begin
                        out_data_d  = lane_q;
                        out_cnt_d   = idx_q;
                        out_valid_d = 1'b1;
                        idle_d      = '0;
                        state_d     = EMIT;
                    end
                end else begin
                    idle_d = '0;
                end
            end

            WAIT: begin
                lat_d = lat_q - 1'b1;
                // lat_q == 1 is the cycle the counter reaches 0 and FIFO_DATA is valid.
                if (lat_q == LAT_W'(1)) begin
                    for (int i = 0; i < P_PACK; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            lane_d[i*P_DATA_WIDTH +: P_DATA_WIDTH] = FIFO_DATA;
                        end
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_d == IDX_W'(P_PACK)) begin
                        out_data_d  = lane_d;
                        out_cnt_d   = idx_d;
                        out_valid_d = 1'b1;
                        state_d     = EMIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            EMIT: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    idx_d       = '0;
                    lane_d      = '0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: the read pulse is combinational so the FIFO sees it in the IDLE
    // cycle itself, which is what makes FIFO_DATA land exactly P_RD_LAT later.
    always_comb begin
        fifo_r_en = 1'b0;
        if ((state_q == IDLE) && !FIFO_EMPTY && !RST) begin
            fifo_r_en = 1'b1;
        end
    end

    assign FIFO_R_EN = fifo_r_en;
    assign OUT_DATA  = out_data_q;
    assign OUT_CNT   = out_cnt_q;
    assign OUT_VALID = out_valid_q;

`ifdef PACK_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = ^out_data_d;
    end

    always_ff @(posedge CON_CLK) begin
        if (RST) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign OUT_PARITY = parity_q;
`endif

endmodule
